// File: rtl/decode_stage_pipelined.sv
// Pipelined decode stage: IF/ID latch, register file with write-through bypass,
// load-use hazard detection, and an ID/EX output latch.
module decode_stage_pipelined #(
   parameter int N         = 32,
   parameter int NREGS     = 16,
   parameter int RA        = 4,
   parameter int PC_REG    = 15,
   parameter int PC_OFFSET = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [31:0]   in_inst,
   input  logic [N-1:0]  in_pc,
   input  logic          flush,
   input  logic          ex_stall,
   input  logic          reg_write,
   input  logic [RA-1:0] wa,
   input  logic [N-1:0]  wd,
   input  logic          reg_src_a1,
   input  logic          reg_src_a2,
   output logic          stall_if,
   output logic          out_valid,
   output logic [N-1:0]  out_rd1,
   output logic [N-1:0]  out_rd2,
   output logic [RA-1:0] out_rd,
   output logic [4:0]    out_cmd,
   output logic [1:0]    out_op,
   output logic [2:0]    out_cond,
   output logic          out_imm_flag,
   output logic [N-1:0]  out_imm_ext,
   output logic          out_is_load,
   output logic [N-1:0]  dbg_r0,
   output logic [N-1:0]  dbg_r1
);

   localparam logic [RA-1:0] PC_A = RA'(PC_REG);

   logic          ifid_valid;
   logic [31:0]   ifid_inst;
   logic [N-1:0]  ifid_pc;
   logic [N-1:0]  regs [NREGS];

   logic [3:0]    f_rd, f_rn, f_rs;
   logic [RA-1:0] rd_a, rn_a, rs_a, a1, a2;
   logic [N-1:0]  rd1, rd2, pc_val, imm_ext;
   logic          dec_is_load, hz;

   assign f_rd = ifid_inst[20:17];
   assign f_rn = ifid_inst[16:13];
   assign f_rs = ifid_inst[3:0];
   assign rd_a = RA'(f_rd);
   assign rn_a = RA'(f_rn);
   assign rs_a = RA'(f_rs);

   assign a1 = reg_src_a1 ? PC_A : rn_a;
   assign a2 = reg_src_a2 ? rd_a : rs_a;

   assign pc_val      = ifid_pc + N'(PC_OFFSET);
   assign imm_ext     = {{(N-13){ifid_inst[12]}}, ifid_inst[12:0]};
   assign dec_is_load = (ifid_inst[28:27] == 2'b01) && ifid_inst[21];

   // PC_REG is never a storage location; the bypass only applies to real registers
   function automatic logic [N-1:0] rf_read(input logic [RA-1:0] a,
                                            input logic [N-1:0] stored);
      if (a == PC_A)                  return pc_val;
      else if (reg_write && wa == a)  return wd;
      else                            return stored;
   endfunction

   assign rd1 = rf_read(a1, regs[a1]);
   assign rd2 = rf_read(a2, regs[a2]);

   assign hz = out_valid && out_is_load && ifid_valid &&
               ((a1 == out_rd && a1 != PC_A) || (a2 == out_rd && a2 != PC_A));
   assign stall_if = hz || ex_stall;

   assign dbg_r0 = regs[0];
   assign dbg_r1 = regs[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (reg_write && wa != PC_A) begin
         regs[wa] <= wd;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ifid_valid <= 1'b0;
         ifid_inst  <= '0;
         ifid_pc    <= '0;
      end else if (flush) begin
         ifid_valid <= 1'b0;
      end else if (!stall_if) begin
         ifid_valid <= in_valid;
         ifid_inst  <= in_inst;
         ifid_pc    <= in_pc;
      end
   end

   // A bubble only clears valid; data fields simply hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid    <= 1'b0;
         out_rd1      <= '0;
         out_rd2      <= '0;
         out_rd       <= '0;
         out_cmd      <= '0;
         out_op       <= '0;
         out_cond     <= '0;
         out_imm_flag <= 1'b0;
         out_imm_ext  <= '0;
         out_is_load  <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (ex_stall) begin
         out_valid <= out_valid;
      end else if (hz) begin
         out_valid <= 1'b0;
      end else begin
         out_valid    <= ifid_valid;
         out_rd1      <= rd1;
         out_rd2      <= rd2;
         out_rd       <= rd_a;
         out_cmd      <= ifid_inst[25:21];
         out_op       <= ifid_inst[28:27];
         out_cond     <= ifid_inst[31:29];
         out_imm_flag <= ifid_inst[26];
         out_imm_ext  <= imm_ext;
         out_is_load  <= dec_is_load;
      end
   end

endmodule

// File: doc/decode_stage_pipelined.md
Name: decode_stage_pipelined

Overview:
Parametrised successor to the combinational decode stage. It adds a registered IF/ID input latch and a registered ID/EX output latch, and contains a parametrised register file with write-through bypass. It also detects load-use hazards, inserting a bubble and stalling fetch, and handles flush and downstream stall. It sits between fetch and execute in the pipelined core.

Parameters:
N, 32, datapath/register width in bits; legal range 16 to 64.
NREGS, 16, number of architectural registers; must be a power of 2.
RA, 4, register address width; equals log2(NREGS).
PC_REG, 15, register index that reads as the PC.
PC_OFFSET, 8, value added to the latched PC when PC_REG is read.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  fetch presents a valid instruction.
in_inst  in  32  instruction word.
in_pc  in  N  PC of in_inst.
flush  in  1  branch taken in EX; kill the instructions in IF/ID and ID/EX.
ex_stall  in  1  execute cannot accept; hold ID/EX.
reg_write  in  1  writeback enable.
wa  in  RA  writeback address.
wd  in  N  writeback data.
reg_src_a1  in  1  1: A1=PC_REG, 0: A1=Rn.
reg_src_a2  in  1  1: A2=Rd, 0: A2=Rs.
stall_if  out  1  fetch must hold PC and in_inst.
out_valid  out  1  ID/EX contents valid.
out_rd1, out_rd2  out  N  operand values.
out_rd  out  RA  destination register.
out_cmd  out  5  inst[25:21].
out_op  out  2  inst[28:27].
out_cond  out  3  inst[31:29].
out_imm_flag  out  1  inst[26].
out_imm_ext  out  N  inst[12:0] sign-extended to N bits.
out_is_load  out  1  op==2'b01 && cmd[0].
dbg_r0, dbg_r1  out  N  live contents of R0 and R1.

Behaviour:
- Reset (asynchronous, immediate):
  - IF/ID valid, ID/EX valid and all out_* clear to 0.
  - All NREGS registers clear to 0.
  - stall_if is 0.
- Field decode from the IF/ID instruction:
  - Rd=[20:17], Rn=[16:13], Rs=[3:0].
  - Only the low RA bits of each field are used.
- Register file:
  - Write is synchronous on clk when reg_write=1 and wa!=PC_REG; writes to PC_REG are ignored.
  - Reads are combinational.
  - Read of PC_REG returns the IF/ID PC + PC_OFFSET, modulo 2^N.
  - Bypass: if reg_write=1 and wa==read address (not PC_REG), the read returns wd in the same cycle.
- Hazard detection:
  - hz = ID/EX valid & out_is_load & IF/ID valid & ((A1==out_rd & A1!=PC_REG) | (A2==out_rd & A2!=PC_REG)).
- stall_if = hz | ex_stall (combinational).
- IF/ID latch, per clock, in priority order:
  - flush: valid<=0.
  - else stall_if: hold.
  - else: load in_valid, in_inst, in_pc.
- ID/EX latch, per clock, in priority order:
  - flush: valid<=0.
  - else ex_stall: hold all fields.
  - else hz: valid<=0 (bubble); data fields don't-care.
  - else: load the decoded fields and operands; valid<=IF/ID valid.
- Latency: one cycle from IF/ID to ID/EX. With no hazard, in_inst accepted at edge k appears on out_* after edge k+1.
- Simultaneous flush and ex_stall: flush wins.
- Simultaneous write and read of the same register: the bypassed new value is captured.

Test Plan:
- Reset mid-stream: assert rst with out_valid=1 -> out_valid, out_rd1 and dbg_r0 read 0 immediately, before the next clk edge.
- Write then read: write R3=0x0000_1234 while an instruction with Rn=3 (reg_src_a1=0) sits in IF/ID -> out_rd1=0x0000_1234 one edge later (bypass).
- PC read: IF/ID pc=0x100, reg_src_a1=1 -> out_rd1=0x108; writing wa=15 leaves the read unchanged.
- Load-use: load to R2 in ID/EX (out_is_load=1, out_rd=2), next instruction has Rs=2 -> stall_if=1 for exactly one cycle and one bubble (out_valid=0). The dependent instruction then issues with its operand.
- Flush: flush=1 with both latches valid -> out_valid=0 and IF/ID invalid after the edge, even if ex_stall=1 in the same cycle.
- Immediate: inst[12:0]=0x1FFF -> out_imm_ext=0xFFFF_FFFF; inst[12:0]=0x0FFF -> 0x0000_0FFF.
